bank_writer: RTL and testbench
==============================

Name: bank_writer

Overview:
- Write-side controller for the 8x4 register bank: converts raw user inputs (address/data switches, write and clear push-buttons) into clean bank write transactions.
- Every write is read back through one bank read port and compared with the value written.
- Sits between board I/O and the bank write port (addrW/datW/RegWrite) and one read port (rd_addr/rd_data); the display path stays on the other read port.

Parameters:
DEB_CYCLES, 250000, consecutive stable cycles required to accept a button level change (5 ms at 50 MHz; bench uses 4)
AW, 3, bank address width (bank depth 2**AW)
DW, 4, bank data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
btn_wr  in  1  raw async write button, active high
btn_clr  in  1  raw async clear-all button, active high
sw_addr  in  AW  target register address (switches)
sw_data  in  DW  data to write (switches)
rd_data  in  DW  bank combinational read data for rd_addr
addrW  out  AW  bank write address
datW  out  DW  bank write data
RegWrite  out  1  bank write enable
rd_addr  out  AW  bank read address used for verification
busy  out  1  high whenever FSM is not IDLE
done  out  1  one-cycle pulse at the end of each write or clear operation
err  out  1  sticky readback-mismatch flag

Behaviour:
- Reset (sync, active-high): all outputs 0, FSM=IDLE, synchronizers/debounce levels/counters 0, err cleared. Reset mid-operation aborts at that edge; RegWrite is low from the next cycle; partial clear is not resumed.
- Per-button input path:
  - 2-FF synchronizer to s.
  - Debounced level deb changes to s on the DEB_CYCLES-th consecutive edge at which s != deb. The counter restarts whenever s == deb.
  - req = deb & ~deb_q, where deb_q is deb registered. One pulse per press; release generates nothing.
- Latency: if edge k is the first to sample a held-high btn_wr, FSM leaves IDLE at edge k+DEB_CYCLES+2. RegWrite is high for exactly the following cycle.
- FSM states: IDLE, WRITE, CHECK, CLR_WR, CLR_CHK.
  - IDLE:
    - req_clr -> CLR_WR, clear index idx=0.
    - Else req_wr -> WRITE; latch addrW=sw_addr and datW=sw_data at this edge.
    - Both requests in the same cycle: clear wins and the write request is dropped.
  - WRITE: RegWrite=1 for one cycle. Bank captures the data at the end of this cycle. -> CHECK.
  - CHECK: rd_addr=addrW. At the end of the cycle compare rd_data with datW; mismatch sets err. -> IDLE with done=1 for one cycle.
  - CLR_WR: addrW=idx, datW=0, RegWrite=1. -> CLR_CHK.
  - CLR_CHK: rd_addr=idx. rd_data!=0 sets err. If idx==2**AW-1 -> IDLE with done pulse; else idx+1 -> CLR_WR.
  - Single write = 2 busy cycles. Clear = 2*2**AW busy cycles (16 at AW=3).
- RegWrite is decoded from state (WRITE or CLR_WR) and is never high in two consecutive cycles.
- Switch changes while busy do not affect the latched addrW/datW.
- Requests arriving while busy are discarded; no queueing. Debounce keeps running, so a button still held does not re-trigger.
- err stays set until rst. busy=0 only in IDLE. rd_addr holds its last value in IDLE.
- idx wraps only by FSM exit; no overflow is possible.

Test Plan:
1. DEB_CYCLES=4, rst 2 cycles -> all outputs 0. Press btn_wr (sw_addr=5, sw_data=0xA) held 20 cycles -> one RegWrite pulse with addrW=5, datW=0xA at edge k+6. CHECK reads 0xA; done pulses; err=0.
2. btn_wr bounces 1-0-1-0 with 2-cycle periods, then stays high -> exactly one write. Bounces shorter than 4 cycles generate no write.
3. btn_clr press after registers 0..7 are loaded with 0x1..0x8 -> 8 RegWrite pulses on alternating cycles, addrW 0..7 with datW=0. busy is high 16 cycles, then done pulses; bank reads all 0; err=0.
4. Bench model forces rd_data=0x3 during CHECK of a write of 0xC -> err=1, and it stays 1 through later good writes until rst.
5. btn_wr and btn_clr debounced on the same cycle -> clear sequence only; no single write. btn_wr pressed during the clear -> ignored, with no write after done.
6. rst asserted during CLR_WR at idx=3 -> next cycle RegWrite=0, busy=0, FSM IDLE. A new btn_wr press then completes a normal write.

Source files
------------

// File: rtl/bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : bank_writer
// Purpose  : Write-side controller for a 2**AW x DW register bank. Turns raw
//            switch/push-button inputs into clean, single-cycle bank writes
//            and reads every written location back through one bank read
//            port to confirm it.
// Ports    : clk, rst        - clock (rising edge), synchronous active-high reset
//            btn_wr, btn_clr - raw asynchronous write / clear-all buttons
//            sw_addr, sw_data- target address / data switches
//            rd_data         - bank read data for rd_addr (combinational)
//            addrW, datW     - bank write address / data
//            RegWrite        - bank write enable
//            rd_addr         - bank read address used for verification
//            busy            - high whenever the controller is not idle
//            done            - one-cycle pulse after each write/clear operation
//            err             - sticky readback-mismatch flag (cleared by rst)
// Revision : 1.0 - initial release
// ============================================================================
module bank_writer #(
  parameter int DEB_CYCLES = 250000,
  parameter int AW         = 3,
  parameter int DW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_wr,
  input  logic          btn_clr,
  input  logic [AW-1:0] sw_addr,
  input  logic [DW-1:0] sw_data,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] addrW,
  output logic [DW-1:0] datW,
  output logic          RegWrite,
  output logic [AW-1:0] rd_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST = '1;

  // --------------------------------------------------------------------------
  // Button conditioning. Bit 0 = write button, bit 1 = clear button.
  // --------------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [CW-1:0] cnt [2];
  logic          req_wr;
  logic          req_clr;

  assign raw = {btn_clr, btn_wr};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int b = 0; b < 2; b++) cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int b = 0; b < 2; b++) begin
        // Any edge where the synchronized level agrees with the debounced
        // level restarts the run; the level flips on the DEB_CYCLES-th
        // consecutive disagreeing edge.
        if (sync2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          deb[b] <= sync2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases generate nothing.
  assign req_wr  = deb[0] & ~deb_q[0];
  assign req_clr = deb[1] & ~deb_q[1];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    CHECK   = 3'd2,
    CLR_WR  = 3'd3,
    CLR_CHK = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    RegWrite = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Clear has priority; a simultaneous write request is dropped.
        if (req_clr)     state_nx = CLR_WR;
        else if (req_wr) state_nx = WRITE;
      end
      WRITE: begin
        RegWrite = 1'b1;
        state_nx = CHECK;
      end
      CHECK:   state_nx = IDLE;
      CLR_WR: begin
        RegWrite = 1'b1;
        state_nx = CLR_CHK;
      end
      CLR_CHK: state_nx = (idx == IDX_LAST) ? IDLE : CLR_WR;
      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: write address/data latch, readback address, checks, done.
  // addrW/datW are only loaded on entry to an operation (or per clear step),
  // so switch activity while busy never disturbs an operation in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addrW   <= '0;
      datW    <= '0;
      rd_addr <= '0;
      idx     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_clr) begin
            idx   <= '0;
            addrW <= '0;
            datW  <= '0;
          end else if (req_wr) begin
            addrW <= sw_addr;
            datW  <= sw_data;
          end
        end
        WRITE:  rd_addr <= addrW;
        CHECK: begin
          if (rd_data != datW) err <= 1'b1;
          done <= 1'b1;
        end
        CLR_WR: rd_addr <= idx;
        CLR_CHK: begin
          if (rd_data != '0) err <= 1'b1;
          if (idx == IDX_LAST) begin
            done <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            addrW <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_writer
// Purpose  : Self-checking bench for bank_writer with a behavioural 8x4 bank
//            model, table-driven loads, directed corner sequences and random
//            writes checked against a reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_writer;

  localparam int DEB = 4;
  localparam int AW  = 3;
  localparam int DW  = 4;
  localparam int N   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_wr = 1'b0;
  logic          btn_clr = 1'b0;
  logic [AW-1:0] sw_addr = '0;
  logic [DW-1:0] sw_data = '0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] addrW;
  logic [DW-1:0] datW;
  logic          RegWrite;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic          err;

  bank_writer #(.DEB_CYCLES(DEB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .btn_wr(btn_wr), .btn_clr(btn_clr),
    .sw_addr(sw_addr), .sw_data(sw_data), .rd_data(rd_data),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite), .rd_addr(rd_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural register bank; force_bad corrupts the readback value.
  logic [DW-1:0] mem [N];
  logic          force_bad = 1'b0;
  always @(posedge clk) if (RegWrite) mem[addrW] <= datW;
  assign rd_data = force_bad ? 4'h3 : mem[rd_addr];

  int checks = 0;
  int errors = 0;

  // Transaction monitor: every bank write is logged as {addr,data}.
  logic [AW+DW-1:0] log_q[$];
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic prev_rw  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (RegWrite) begin
        log_q.push_back({addrW, datW});
        checks++;
        if (prev_rw) begin
          errors++;
          $display("FAIL regwrite_back_to_back actual=1 required=0 t=%0t", $time);
        end
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    prev_rw = RegWrite;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic press(input bit wr, input bit clr, input int hold);
    btn_wr  = wr;
    btn_clr = clr;
    repeat (hold) tick();
    btn_wr  = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 0, 1);
  endtask

  task automatic settle();
    repeat (12) tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    int st = done_cnt;
    sw_addr = a;
    sw_data = d;
    press(1'b1, 1'b0, hold);
    wait_done(st);
    settle();
  endtask

  // Clear checks shared by the clear sequences: N writes, addr i, data 0.
  task automatic check_clear_log(input string tag);
    chk({tag, "_nwrites"}, log_q.size(), N);
    for (int i = 0; i < N && i < log_q.size(); i++) begin
      chk({tag, "_addr"}, int'(log_q[i][AW+DW-1:DW]), i);
      chk({tag, "_data"}, int'(log_q[i][DW-1:0]), 0);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            hold;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t          tbl [N];
  logic [DW-1:0] exp_mem [N];

  initial begin
    int n, st;
    for (int i = 0; i < N; i++)
      tbl[i] = '{addr: AW'(i), data: DW'(i + 1), hold: 6 + i,
                 exp_addr: AW'(i), exp_data: DW'(i + 1)};

    // ---- Reset state ----
    do_reset();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addrW", addrW, 0);
    chk("rst_datW", datW, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // ---- Single write latency: RegWrite in the cycle after edge k+6 ----
    log_q.delete();
    done_cnt = 0;
    sw_addr = 3'd5;
    sw_data = 4'hA;
    btn_wr  = 1'b1;
    n = 0;
    while (!RegWrite && n < 50) begin
      tick();
      n++;
    end
    chk("wr_latency_edges", n, DEB + 3);
    chk("wr_addrW", addrW, 5);
    chk("wr_datW", datW, 4'hA);
    chk("wr_busy", busy, 1);
    // Switch changes mid-operation must not affect the latched values.
    sw_addr = 3'd0;
    sw_data = 4'h0;
    repeat (19 - n) tick();
    btn_wr = 1'b0;
    settle();
    chk("wr_nwrites", log_q.size(), 1);
    chk("wr_done_pulses", done_cnt, 1);
    chk("wr_mem5", mem[5], 4'hA);
    chk("wr_err", err, 0);

    // ---- Bounce shorter than the debounce window: no write ----
    log_q.delete();
    sw_addr = 3'd6;
    sw_data = 4'h9;
    for (int i = 0; i < 8; i++) begin
      btn_wr = ((i / 2) % 2) == 0;
      tick();
    end
    btn_wr = 1'b0;
    settle();
    chk("bounce_only_nwrites", log_q.size(), 0);

    // ---- Bounce then stable high: exactly one write ----
    for (int i = 0; i < 8; i++) begin
      btn_wr = ((i / 2) % 2) == 0;
      tick();
    end
    press(1'b1, 1'b0, 12);
    settle();
    chk("bounce_nwrites", log_q.size(), 1);
    if (log_q.size() > 0) chk("bounce_entry", int'(log_q[0]), int'({3'd6, 4'h9}));

    // ---- Table-driven loads of registers 0..N-1 ----
    for (int i = 0; i < N; i++) begin
      log_q.delete();
      do_write(tbl[i].addr, tbl[i].data, tbl[i].hold);
      chk("tbl_nwrites", log_q.size(), 1);
      if (log_q.size() > 0) begin
        chk("tbl_addrW", int'(log_q[0][AW+DW-1:DW]), tbl[i].exp_addr);
        chk("tbl_datW", int'(log_q[0][DW-1:0]), tbl[i].exp_data);
      end
    end
    for (int i = 0; i < N; i++) chk("tbl_mem", mem[i], i + 1);

    // ---- Clear all ----
    log_q.delete();
    busy_cnt = 0;
    st = done_cnt;
    press(1'b0, 1'b1, 10);
    wait_done(st);
    settle();
    check_clear_log("clr");
    chk("clr_busy_cycles", busy_cnt, 2 * N);
    chk("clr_done_pulses", done_cnt - st, 1);
    for (int i = 0; i < N; i++) chk("clr_mem", mem[i], 0);
    chk("clr_err", err, 0);

    // ---- Simultaneous write+clear: clear only ----
    do_write(3'd1, 4'h7, 8);
    log_q.delete();
    sw_addr = 3'd4;
    sw_data = 4'hF;
    st = done_cnt;
    press(1'b1, 1'b1, 10);
    wait_done(st);
    settle();
    check_clear_log("both");
    chk("both_mem1", mem[1], 0);

    // ---- Write pressed during a clear: ignored ----
    log_q.delete();
    st = done_cnt;
    press(1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 10);
    wait_done(st);
    settle();
    check_clear_log("wr_in_clr");
    chk("wr_in_clr_done", done_cnt - st, 1);

    // ---- Random writes against a reference memory ----
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    for (int t = 0; t < 12; t++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(N - 1, 0));
      d = DW'($urandom_range(15, 0));
      exp_mem[a] = d;
      log_q.delete();
      do_write(a, d, int'($urandom_range(15, 6)));
      chk("rnd_nwrites", log_q.size(), 1);
      if (log_q.size() > 0) chk("rnd_entry", int'(log_q[0]), int'({a, d}));
    end
    for (int i = 0; i < N; i++) chk("rnd_mem", mem[i], exp_mem[i]);
    chk("rnd_err", err, 0);

    // ---- Readback mismatch: sticky err ----
    force_bad = 1'b1;
    do_write(3'd2, 4'hC, 8);
    force_bad = 1'b0;
    chk("bad_err_set", err, 1);
    chk("bad_mem2", mem[2], 4'hC);
    do_write(3'd3, 4'h5, 8);
    chk("bad_err_sticky", err, 1);
    do_reset();
    chk("bad_err_rst", err, 0);

    // ---- Reset during clear at idx 3 ----
    log_q.delete();
    press(1'b0, 1'b1, 8);
    n = 0;
    while (!(RegWrite && addrW == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reached_idx3", int'(RegWrite && addrW == 3'd3), 1);
    rst = 1'b1;
    tick();
    chk("abort_regwrite", RegWrite, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    settle();
    chk("abort_nwrites", log_q.size(), 4);
    chk("abort_busy_after", busy, 0);
    log_q.delete();
    do_write(3'd6, 4'hB, 8);
    chk("abort_new_nwrites", log_q.size(), 1);
    if (log_q.size() > 0) chk("abort_new_entry", int'(log_q[0]), int'({3'd6, 4'hB}));
    chk("abort_new_mem", mem[6], 4'hB);
    chk("abort_new_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
